// File: rtl/soc_addr_map_cfg.sv
// soc_addr_map_cfg
//   Runtime-programmable SoC address decoder. It holds NrRules {base, length, valid}
//   rules that reset to the SoC memory map. The rules can be rewritten through a
//   req/gnt config port. Each accepted lookup gives a registered slave index and a
//   hit/miss flag one cycle later.
//
//   Optional feature macro: ADDR_MAP_LOCK_EN
//     When defined, field 3 at index 0 is a sticky lock bit. It is set by writing 1
//     and cleared only by reset. While it is set, every write is rejected with an error.
//     When undefined, field 3 is always an error and no lock state exists.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   cfg_req_i / cfg_gnt_o    config request, always granted in the same cycle
//   cfg_we_i                 1 = write, 0 = read
//   cfg_idx_i, cfg_field_i   rule index; field 0=base 1=length 2=valid 3=ctrl
//   cfg_wdata_i              write data
//   cfg_rvalid_o             one-cycle response, one cycle after the grant
//   cfg_rdata_o, cfg_err_o   read data and error flag, qualified by cfg_rvalid_o
//   lkp_valid_i/lkp_ready_o  lookup request handshake
//   lkp_addr_i               address to decode
//   lkp_valid_o/lkp_ready_i  lookup result handshake
//   lkp_idx_o, lkp_hit_o     matched rule (lowest index wins), hit flag (0 = decode error)
module soc_addr_map_cfg #(
  parameter int unsigned NrRules   = 9,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase = {
    64'h0000_0000_6000_0000,   // 8 ext periph
    64'h0000_0000_0C00_0000,   // 7 PLIC
    64'h0000_0000_0200_0000,   // 6 CLINT
    64'h0000_0000_1000_1000,   // 5 GPIO
    64'h0000_0000_1000_0000,   // 4 UART
    64'h0000_0000_2000_0000,   // 3 SPI flash window (inside rule 1)
    64'h0000_0000_0000_0000,   // 2 boot ROM
    64'h0000_0000_2000_0000,   // 1 peripheral bus
    64'h0000_0000_8000_0000},  // 0 DRAM
  parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = {
    64'h0000_0000_1000_0000,
    64'h0000_0000_0400_0000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0000_1000,
    64'h0000_0000_0100_0000,
    64'h0000_0000_0001_0000,
    64'h0000_0000_1000_0000,
    64'h0000_0000_1000_0000},
  parameter logic [NrRules-1:0] RstValid = '1,
  localparam int unsigned IdxWidth = $clog2(NrRules)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_valid_o,
  input  logic                 lkp_ready_i,
  output logic [IdxWidth-1:0]  lkp_idx_o,
  output logic                 lkp_hit_o
);

  // One extra bit so that the compare is correct when NrRules is a power of two.
  localparam logic [IdxWidth:0] NrRulesW = (IdxWidth+1)'(NrRules);

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [NrRules-1:0]   valid_q;

  logic                 lkp_valid_q;
  logic [IdxWidth-1:0]  lkp_idx_q, lkp_idx_d;
  logic                 lkp_hit_q, lkp_hit_d;

  logic                 cfg_rvalid_q;
  logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 idx_ok;
  logic                 wr_en;

`ifdef ADDR_MAP_LOCK_EN
  logic                 lock_q;
  logic                 lock_set;
`endif

  // The compare addr >= base comes first. Because of it, addr - base cannot wrap.
  // This keeps rules that end at the top of the address space correct.
  // A length of 0 can never satisfy the "< length" test.
  function automatic logic rule_match(input logic [AddrWidth-1:0] addr,
                                      input logic [AddrWidth-1:0] base,
                                      input logic [AddrWidth-1:0] len,
                                      input logic                 vld);
    return vld && (addr >= base) && ((addr - base) < len);
  endfunction

  // The scan runs from the highest index down. The lowest matching rule is written
  // last, so it wins.
  always_comb begin
    lkp_idx_d = '0;
    lkp_hit_d = 1'b0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (rule_match(lkp_addr_i, base_q[i], len_q[i], valid_q[i])) begin
        lkp_idx_d = IdxWidth'(i);
        lkp_hit_d = 1'b1;
      end
    end
  end

  assign lkp_ready_o = !lkp_valid_q || lkp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lkp_valid_q <= 1'b0;
      lkp_idx_q   <= '0;
      lkp_hit_q   <= 1'b0;
    end else if (lkp_ready_o) begin
      lkp_valid_q <= lkp_valid_i;
      if (lkp_valid_i) begin
        lkp_idx_q <= lkp_idx_d;
        lkp_hit_q <= lkp_hit_d;
      end
    end
  end

  assign lkp_valid_o = lkp_valid_q;
  assign lkp_idx_o   = lkp_idx_q;
  assign lkp_hit_o   = lkp_hit_q;

  // Config decode: error classification, read mux and write enable.
  always_comb begin
    idx_ok      = ({1'b0, cfg_idx_i} < NrRulesW);
    cfg_err_d   = 1'b0;
    cfg_rdata_d = '0;
    if (!idx_ok) begin
      cfg_err_d = 1'b1;
    end else begin
      case (cfg_field_i)
        2'd0:    cfg_rdata_d = base_q[cfg_idx_i];
        2'd1:    cfg_rdata_d = len_q[cfg_idx_i];
        2'd2:    cfg_rdata_d = {{(AddrWidth-1){1'b0}}, valid_q[cfg_idx_i]};
        default: begin
`ifdef ADDR_MAP_LOCK_EN
          if (cfg_idx_i == '0) cfg_rdata_d = {{(AddrWidth-1){1'b0}}, lock_q};
          else                 cfg_err_d   = 1'b1;
`else
          cfg_err_d = 1'b1;
`endif
        end
      endcase
    end
`ifdef ADDR_MAP_LOCK_EN
    if (lock_q && cfg_we_i) cfg_err_d = 1'b1;
`endif
    // Write responses and failed accesses return zero data.
    if (cfg_err_d || cfg_we_i) cfg_rdata_d = '0;
    wr_en = cfg_req_i && cfg_we_i && !cfg_err_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= RstBase[i];
        len_q[i]  <= RstLength[i];
      end
      valid_q <= RstValid;
    end else if (wr_en) begin
      case (cfg_field_i)
        2'd0:    base_q[cfg_idx_i]  <= cfg_wdata_i;
        2'd1:    len_q[cfg_idx_i]   <= cfg_wdata_i;
        2'd2:    valid_q[cfg_idx_i] <= cfg_wdata_i[0];
        default: ;
      endcase
    end
  end

`ifdef ADDR_MAP_LOCK_EN
  assign lock_set = wr_en && (cfg_field_i == 2'd3) && cfg_wdata_i[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       lock_q <= 1'b0;
    else if (lock_set) lock_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_q <= 1'b0;
      cfg_rdata_q  <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_rvalid_q <= cfg_req_i;
      cfg_rdata_q  <= cfg_req_i ? cfg_rdata_d : '0;
      cfg_err_q    <= cfg_req_i && cfg_err_d;
    end
  end

  assign cfg_gnt_o    = cfg_req_i;
  assign cfg_rvalid_o = cfg_rvalid_q;
  assign cfg_rdata_o  = cfg_rdata_q;
  assign cfg_err_o    = cfg_err_q;

endmodule
